add_serial_seq: RTL and testbench

Bit-serial add/subtract sequencer that time-shares a single `add1pg` full-adder cell (s = a^b^c, p = a^b, g = a&b) across a WIDTH-bit operation. It processes one bit per cycle, LSB first, and holds the ripple carry in a flop. It also accumulates group propagate/generate and overflow. It sits beside the ALU as the area-minimal adder path for slow or low-power operations, with a valid/ready request port and a valid/ready result port.

---
 rtl/add_serial_seq_if.sv | 24 ++
 rtl/add_serial_seq.sv | 84 ++++++++
 tb/tb_add_serial_seq.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/add_serial_seq_if.sv
// add_serial_seq_if: request/result handshake bundle for the bit-serial adder sequencer.
interface add_serial_seq_if #(parameter int WIDTH = 32);
  logic start_valid;
  logic start_ready;
  logic sub;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic flush;
  logic res_valid;
  logic res_ready;
  logic [WIDTH-1:0] sum;
  logic cout;
  logic ovf;
  logic grp_p;
  logic grp_g;
  modport master (
    output start_valid, sub, op_a, op_b, flush, res_ready,
    input  start_ready, res_valid, sum, cout, ovf, grp_p, grp_g
  );
  modport slave (
    input  start_valid, sub, op_a, op_b, flush, res_ready,
    output start_ready, res_valid, sum, cout, ovf, grp_p, grp_g
  );
endinterface

// File: rtl/add_serial_seq.sv
// add_serial_seq: bit-serial add/subtract sequencer time-sharing one external add1pg cell, LSB first.
module add_serial_seq #(
  parameter int WIDTH = 32
) (
  input  logic clk,
  input  logic rst_n,
  add_serial_seq_if.slave bus,
  output logic cell_a,
  output logic cell_b,
  output logic cell_c,
  input  logic cell_s,
  input  logic cell_p,
  input  logic cell_g
);
  localparam int LW = $clog2(WIDTH);
  localparam int IW = LW + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] a_q, b_q, s_q, s_nxt;
  logic [IW-1:0] idx;
  logic carry, gp, gg, nc, last, run;
  assign run = state == RUN;
  assign bus.start_ready = state == IDLE;
  assign bus.res_valid = state == DONE;
  assign cell_a = run ? a_q[idx[LW-1:0]] : 1'b0;
  assign cell_b = run ? b_q[idx[LW-1:0]] : 1'b0;
  assign cell_c = run ? carry : 1'b0;
  assign nc = cell_g | (cell_p & cell_c);
  assign last = idx == IW'(WIDTH - 1);
  always_comb begin
    s_nxt = s_q;
    s_nxt[idx[LW-1:0]] = cell_s;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_q <= '0;
      b_q <= '0;
      s_q <= '0;
      idx <= '0;
      carry <= 1'b0;
      gp <= 1'b0;
      gg <= 1'b0;
      bus.sum <= '0;
      bus.cout <= 1'b0;
      bus.ovf <= 1'b0;
      bus.grp_p <= 1'b0;
      bus.grp_g <= 1'b0;
    end else if (bus.flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (bus.start_valid) begin
          a_q <= bus.op_a;
          b_q <= bus.op_b ^ {WIDTH{bus.sub}};
          carry <= bus.sub;
          s_q <= '0;
          idx <= '0;
          gp <= 1'b1;
          gg <= 1'b0;
          state <= RUN;
        end
        RUN: begin
          s_q <= s_nxt;
          carry <= nc;
          gp <= gp & cell_p;
          gg <= cell_g | (cell_p & gg);
          idx <= last ? idx : idx + 1'b1;
          if (last) begin
            // ovf compares carry into the MSB against carry out of it
            bus.sum <= s_nxt;
            bus.cout <= nc;
            bus.ovf <= carry ^ nc;
            bus.grp_p <= gp & cell_p;
            bus.grp_g <= cell_g | (cell_p & gg);
            state <= DONE;
          end
        end
        DONE: if (bus.res_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_add_serial_seq.sv
// tb_add_serial_seq: directed and random checks of add_serial_seq at WIDTH 8 and 32 against an arithmetic model.
module tb_add_serial_seq;
  typedef struct packed {
    logic [63:0] sum;
    logic cout;
    logic ovf;
    logic gp;
    logic gg;
  } res_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  res_t exp32 = '0;
  always #5 clk = ~clk;
  add_serial_seq_if #(.WIDTH(8)) if8 ();
  add_serial_seq_if #(.WIDTH(32)) if32 ();
  logic a8, b8, c8, a32, b32, c32;
  add_serial_seq #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .bus(if8),
    .cell_a(a8), .cell_b(b8), .cell_c(c8),
    .cell_s(a8 ^ b8 ^ c8), .cell_p(a8 ^ b8), .cell_g(a8 & b8)
  );
  add_serial_seq #(.WIDTH(32)) u32 (
    .clk(clk), .rst_n(rst_n), .bus(if32),
    .cell_a(a32), .cell_b(b32), .cell_c(c32),
    .cell_s(a32 ^ b32 ^ c32), .cell_p(a32 ^ b32), .cell_g(a32 & b32)
  );
  task automatic chk(input string nm, input logic [67:0] act, input logic [67:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", nm, act, want, $time);
    end
  endtask
  // Reference: plain wide arithmetic on masked operands.
  function automatic res_t model(input int w, input logic [63:0] a, input logic [63:0] b, input logic s);
    logic [64:0] m, aa, bb, full, nocin;
    res_t r;
    m = (65'd1 << w) - 65'd1;
    aa = {1'b0, a} & m;
    bb = {1'b0, (s ? ~b : b)} & m;
    full = aa + bb + 65'(s);
    nocin = aa + bb;
    r.sum = full[63:0] & m[63:0];
    r.cout = full[w];
    r.ovf = (aa[w-1] == bb[w-1]) && (full[w-1] != aa[w-1]);
    r.gp = ((aa ^ bb) & m) == m;
    r.gg = nocin[w];
    return r;
  endfunction
  function automatic res_t got(input bit big);
    res_t r;
    r.sum = big ? {32'd0, if32.sum} : {56'd0, if8.sum};
    r.cout = big ? if32.cout : if8.cout;
    r.ovf = big ? if32.ovf : if8.ovf;
    r.gp = big ? if32.grp_p : if8.grp_p;
    r.gg = big ? if32.grp_g : if8.grp_g;
    return r;
  endfunction
  function automatic logic rdy(input bit big);
    return big ? if32.start_ready : if8.start_ready;
  endfunction
  function automatic logic vld(input bit big);
    return big ? if32.res_valid : if8.res_valid;
  endfunction
  // Per-cycle compare for the 32-bit unit: held result and idle cell drive.
  always @(negedge clk) begin
    if (rst_n) begin
      if (if32.res_valid) chk("done_result", 68'(got(1)), 68'(exp32));
      if (if32.start_ready || if32.res_valid) chk("cell_idle", 68'({a32, b32, c32}), 68'd0);
      if (if8.start_ready || if8.res_valid) chk("cell_idle8", 68'({a8, b8, c8}), 68'd0);
    end
  end
  task automatic accept(input bit big, input logic [63:0] a, input logic [63:0] b, input logic s);
    @(negedge clk);
    if (big) begin
      if32.op_a = a[31:0]; if32.op_b = b[31:0]; if32.sub = s; if32.start_valid = 1'b1;
      exp32 = model(32, a, b, s);
    end else begin
      if8.op_a = a[7:0]; if8.op_b = b[7:0]; if8.sub = s; if8.start_valid = 1'b1;
    end
    @(negedge clk);
    if32.start_valid = 1'b0;
    if8.start_valid = 1'b0;
    chk("busy_after_accept", 68'(rdy(big)), 68'd0);
  endtask
  task automatic op(input bit big, input logic [63:0] a, input logic [63:0] b, input logic s, input int hold);
    int n, w;
    res_t e;
    w = big ? 32 : 8;
    e = model(w, a, b, s);
    accept(big, a, b, s);
    n = 0;
    while (!vld(big) && n < 80) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 68'(n), 68'(w));
    chk("result", 68'(got(big)), 68'(e));
    repeat (hold) begin
      @(negedge clk);
      chk("hold_ready", 68'(rdy(big)), 68'd0);
      chk("hold_valid", 68'(vld(big)), 68'd1);
      chk("hold_result", 68'(got(big)), 68'(e));
    end
    if (big) if32.res_ready = 1'b1; else if8.res_ready = 1'b1;
    @(negedge clk);
    if32.res_ready = 1'b0;
    if8.res_ready = 1'b0;
    chk("taken_ready", 68'(rdy(big)), 68'd1);
    chk("taken_valid", 68'(vld(big)), 68'd0);
  endtask
  initial begin
    if8.start_valid = 0; if8.sub = 0; if8.op_a = 0; if8.op_b = 0; if8.flush = 0; if8.res_ready = 0;
    if32.start_valid = 0; if32.sub = 0; if32.op_a = 0; if32.op_b = 0; if32.flush = 0; if32.res_ready = 0;
    #12;
    chk("rst_result", 68'(got(1)), 68'd0);
    chk("rst_flags", 68'({if32.start_ready, if32.res_valid, a32, b32, c32}), 68'b10000);
    @(negedge clk);
    rst_n = 1'b1;
    chk("pin_5a3c", 68'(model(8, 64'h5A, 64'h3C, 0)), 68'({64'h96, 4'b0100}));
    chk("pin_10m20", 68'(model(8, 64'h10, 64'h20, 1)), 68'({64'hF0, 4'b0000}));
    chk("pin_20m10", 68'(model(8, 64'h20, 64'h10, 1)), 68'({64'h10, 4'b1001}));
    chk("pin_ffp01", 68'(model(8, 64'hFF, 64'h01, 0)), 68'({64'h00, 4'b1001}));
    chk("pin_f00f", 68'(model(8, 64'hF0, 64'h0F, 0)), 68'({64'hFF, 4'b0010}));
    chk("pin_7fff", 68'(model(32, 64'h7FFFFFFF, 64'h1, 0)), 68'({64'h80000000, 4'b0100}));
    chk("pin_8000", 68'(model(32, 64'h80000000, 64'h1, 1)), 68'({64'h7FFFFFFF, 4'b1101}));
    op(0, 64'h5A, 64'h3C, 0, 0);
    op(0, 64'h10, 64'h20, 1, 0);
    op(0, 64'h20, 64'h10, 1, 0);
    op(0, 64'hFF, 64'h01, 0, 0);
    op(0, 64'hF0, 64'h0F, 0, 0);
    op(1, 64'h7FFFFFFF, 64'h1, 0, 0);
    op(1, 64'h80000000, 64'h1, 1, 0);
    op(1, 64'h12345678, 64'h9ABCDEF0, 0, 5);
    op(1, 64'h0, 64'h0, 1, 0);
    // flush three cycles into RUN
    accept(1, 64'hDEADBEEF, 64'h11111111, 0);
    repeat (2) @(negedge clk);
    if32.flush = 1'b1;
    @(negedge clk);
    if32.flush = 1'b0;
    chk("flush_idle", 68'(if32.start_ready), 68'd1);
    repeat (40) begin
      @(negedge clk);
      chk("flush_no_valid", 68'(if32.res_valid), 68'd0);
    end
    op(1, 64'hCAFEF00D, 64'h0BADBEEF, 1, 0);
    // flush wins over a request in IDLE
    @(negedge clk);
    if32.flush = 1'b1;
    if32.start_valid = 1'b1;
    @(negedge clk);
    if32.flush = 1'b0;
    if32.start_valid = 1'b0;
    chk("flush_blocks_accept", 68'(if32.start_ready), 68'd1);
    // reset mid-RUN
    accept(1, 64'hFFFFFFFF, 64'hFFFFFFFF, 0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_result", 68'(got(1)), 68'd0);
    chk("midrun_rst_flags", 68'({if32.start_ready, if32.res_valid, a32, b32, c32}), 68'b10000);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 1000; i++)
      op(1, 64'($urandom), 64'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 2));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
